// File: rtl/pdh_adc_capture.sv
// Triggered multi-channel snapshot buffer for the PDH ADC stream, controlled and
// read back through a toggle-handshake GPIO command/response word pair.
module pdh_adc_capture #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*SAMPLE_W-1:0]   adc_tdata_i,
    input  logic                         adc_tvalid_i,
    input  logic [31:0]                  cmd_i,
    output logic [31:0]                  rsp_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int FRAME_W = NUM_CH * SAMPLE_W;

    localparam logic [ADDR_W:0] WPTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] WPTR_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [7:0]      NUM_CH_B  = 8'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_ARM    = 3'd1,
        OP_ABORT  = 3'd2,
        OP_READ   = 3'd3,
        OP_STATUS = 3'd4
    } op_t;

    // Command decode (stage 0: registered GPIO word)
    logic [31:0]       cmd_q;
    logic              last_tgl;
    logic              cmd_det;
    op_t               cmd_op;
    logic [7:0]        cmd_ch;
    logic [15:0]       cmd_arg;
    logic [ADDR_W-1:0] rd_addr;
    logic              unused_cmd_bits;

    assign cmd_det         = cmd_q[31] != last_tgl;
    assign cmd_op          = op_t'(cmd_q[30:28]);
    assign cmd_ch          = cmd_q[23:16];
    assign cmd_arg         = cmd_q[15:0];
    assign rd_addr         = cmd_q[ADDR_W-1:0];
    assign unused_cmd_bits = ^cmd_q[27:24];

    // Capture control state
    state_t            state, state_d;
    logic [ADDR_W:0]   wptr, wptr_d;
    logic [15:0]       cnt, cnt_d;
    logic [15:0]       decim, decim_d;
    logic              wr_en;
    logic              cmd_err;

    // Response pipeline (stage 1: RAM read and command attributes)
    logic              p1_vld;
    logic              p1_tgl;
    logic              p1_err;
    logic              p1_is_read;
    logic              p1_is_status;
    state_t            p1_state;
    logic [ADDR_W:0]   p1_wptr;
    logic [7:0]        p1_ch;
    logic [FRAME_W-1:0] rd_word;

    logic signed [SAMPLE_W-1:0] samp;
    logic [15:0]                rsp_data;

    logic [FRAME_W-1:0] mem [DEPTH];

    // NOTE: always_comb uses blocking assignments, and every output gets a
    // default first so no path can leave a value held (no latch inferred).
    always_comb begin
        state_d = state;
        wptr_d  = wptr;
        cnt_d   = cnt;
        decim_d = decim;
        wr_en   = 1'b0;
        cmd_err = 1'b0;

        if (state == ST_CAPTURE && adc_tvalid_i) begin
            if (cnt == 16'd0) begin
                wr_en  = 1'b1;
                wptr_d = wptr + WPTR_ONE;
                if (wptr == WPTR_LAST) begin
                    state_d = ST_DONE;
                end
            end
            cnt_d = (cnt == decim) ? 16'd0 : cnt + 16'd1;
        end

        // A command on the same edge as a capture write overrides that write.
        if (cmd_det) begin
            case (cmd_op)
                OP_NOP, OP_STATUS: ;
                OP_ARM: begin
                    state_d = ST_CAPTURE;
                    wptr_d  = '0;
                    cnt_d   = 16'd0;
                    decim_d = cmd_arg;
                    wr_en   = 1'b0;
                end
                OP_ABORT: begin
                    state_d = ST_IDLE;
                    wr_en   = 1'b0;
                end
                OP_READ: begin
                    cmd_err = (state == ST_CAPTURE) || (cmd_ch >= NUM_CH_B);
                end
                default: cmd_err = 1'b1;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q    <= '0;
            last_tgl <= 1'b0;
            state    <= ST_IDLE;
            wptr     <= '0;
            cnt      <= 16'd0;
            decim    <= 16'd0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            cmd_q    <= cmd_i;
            last_tgl <= cmd_q[31];
            state    <= state_d;
            wptr     <= wptr_d;
            cnt      <= cnt_d;
            decim    <= decim_d;
            busy_o   <= (state_d == ST_CAPTURE);
            done_o   <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_vld       <= 1'b0;
            p1_tgl       <= 1'b0;
            p1_err       <= 1'b0;
            p1_is_read   <= 1'b0;
            p1_is_status <= 1'b0;
            p1_state     <= ST_IDLE;
            p1_wptr      <= '0;
            p1_ch        <= 8'd0;
            rsp_o        <= 32'd0;
        end else begin
            p1_vld       <= cmd_det;
            p1_tgl       <= cmd_q[31];
            p1_err       <= cmd_err;
            p1_is_read   <= cmd_det && (cmd_op == OP_READ);
            p1_is_status <= cmd_det && (cmd_op == OP_STATUS);
            p1_state     <= state_d;
            p1_wptr      <= wptr_d;
            p1_ch        <= cmd_ch;
            if (p1_vld) begin
                rsp_o <= {p1_tgl, p1_err, p1_state, 12'h000, rsp_data};
            end
        end
    end

    // NOTE: the sample RAM and its read register have no reset so they map
    // onto block RAM; contents after reset are undefined by design.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[ADDR_W-1:0]] <= adc_tdata_i;
        end
        rd_word <= mem[rd_addr];
    end

    always_comb begin
        samp = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (p1_ch == 8'(k)) begin
                samp = rd_word[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Errors force data to zero; READ sign-extends, STATUS zero-extends.
    always_comb begin
        rsp_data = 16'd0;
        if (!p1_err) begin
            if (p1_is_read) begin
                rsp_data = 16'(samp);
            end else if (p1_is_status) begin
                rsp_data = 16'(p1_wptr);
            end
        end
    end

endmodule

// File: tb/tb_pdh_adc_capture.sv
// Directed bench for pdh_adc_capture (2 channels x 16 bits, 16-frame buffer):
// command latency, capture, decimation, error responses, collisions and reset.
module tb_pdh_adc_capture;

    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 16;
    localparam int DEPTH    = 16;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_ARM    = 3'd1;
    localparam logic [2:0] OP_ABORT  = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_STATUS = 3'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  ch;
        logic [15:0] arg;
        logic        err;
        logic [1:0]  st;
        logic [15:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adc_tdata_i;
    logic        adc_tvalid_i;
    logic [31:0] cmd_i;
    logic [31:0] rsp_o;
    logic        busy_o;
    logic        done_o;

    int   n_vec  = 0;
    int   n_miss = 0;
    logic tgl    = 1'b0;
    int   vcount;
    int   cyc;
    vec_t vecs [11];

    pdh_adc_capture #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_tdata_i  (adc_tdata_i),
        .adc_tvalid_i (adc_tvalid_i),
        .cmd_i        (cmd_i),
        .rsp_o        (rsp_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rsp(input logic err, input logic [1:0] st, input logic [15:0] data);
        return {tgl, err, st, 12'h000, data};
    endfunction

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] ch, input logic [15:0] arg);
        tgl   = ~tgl;
        cmd_i = {tgl, op, 4'h0, ch, arg};
        repeat (3) tick();
    endtask

    task automatic cmd_check(input string name, input logic [2:0] op, input logic [7:0] ch,
                             input logic [15:0] arg, input logic err, input logic [1:0] st,
                             input logic [15:0] data);
        send_cmd(op, ch, arg);
        check(name, rsp_o, exp_rsp(err, st, data));
    endtask

    task automatic frame(input logic valid, input logic [15:0] ch0, input logic [15:0] ch1);
        adc_tvalid_i = valid;
        adc_tdata_i  = {ch1, ch0};
        tick();
        adc_tvalid_i = 1'b0;
    endtask

    task automatic rand_beat();
        if ($urandom_range(1, 0) == 1) begin
            frame(1'b1, 16'(vcount), 16'(vcount) ^ 16'h8000);
            vcount++;
        end else begin
            frame(1'b0, 16'hDEAD, 16'hDEAD);
        end
    endtask

    initial begin
        // Expectations while the buffer holds the D=0 ramp (ch0=i, ch1=-i) and is DONE.
        vecs[0]  = '{OP_READ,   8'd1, 16'd5,     1'b0, S_DONE, 16'hFFFB};
        vecs[1]  = '{OP_READ,   8'd0, 16'd5,     1'b0, S_DONE, 16'h0005};
        vecs[2]  = '{OP_READ,   8'd0, 16'd15,    1'b0, S_DONE, 16'h000F};
        vecs[3]  = '{OP_READ,   8'd1, 16'd15,    1'b0, S_DONE, 16'hFFF1};
        vecs[4]  = '{OP_READ,   8'd1, 16'd0,     1'b0, S_DONE, 16'h0000};
        vecs[5]  = '{OP_READ,   8'd0, 16'h0013,  1'b0, S_DONE, 16'h0003};
        vecs[6]  = '{OP_STATUS, 8'd0, 16'd0,     1'b0, S_DONE, 16'h0010};
        vecs[7]  = '{OP_READ,   8'd2, 16'd5,     1'b1, S_DONE, 16'h0000};
        vecs[8]  = '{3'd7,      8'd0, 16'd0,     1'b1, S_DONE, 16'h0000};
        vecs[9]  = '{3'd5,      8'd0, 16'd1,     1'b1, S_DONE, 16'h0000};
        vecs[10] = '{OP_NOP,    8'd0, 16'd0,     1'b0, S_DONE, 16'h0000};

        rst          = 1'b1;
        cmd_i        = 32'd0;
        adc_tdata_i  = 32'd0;
        adc_tvalid_i = 1'b0;
        repeat (2) tick();
        check("rst_rsp", rsp_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst = 1'b0;
        tick();

        // NOP with toggle 1: response lands on the third edge, not before.
        tgl   = 1'b1;
        cmd_i = 32'h8000_0000;
        repeat (2) tick();
        check("nop_not_early", rsp_o, 32'd0);
        tick();
        check("nop_ack", rsp_o, 32'h8000_0000);
        check("nop_busy", 32'(busy_o), 32'd0);

        // D=0 ramp fills all 16 entries, then DONE; later frames are dropped.
        cmd_check("arm_d0", OP_ARM, 8'd0, 16'd0, 1'b0, S_CAP, 16'h0000);
        check("arm_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            frame(1'b1, 16'(i), 16'(-i));
            check($sformatf("ramp_done_%0d", i), 32'(done_o), 32'(i == DEPTH - 1));
        end
        check("ramp_busy_end", 32'(busy_o), 32'd0);
        frame(1'b1, 16'h7777, 16'h7777);

        for (int v = 0; v < 11; v++) begin
            cmd_check($sformatf("vec%0d", v), vecs[v].op, vecs[v].ch, vecs[v].arg,
                      vecs[v].err, vecs[v].st, vecs[v].data);
        end

        // D=3 with ~50% valid duty: valid beats 0,4,8,... are stored.
        cmd_check("arm_d3", OP_ARM, 8'd0, 16'd3, 1'b0, S_CAP, 16'h0000);
        vcount = 0;
        for (int c = 0; c < 24; c++) begin
            rand_beat();
        end
        cmd_check("d3_status_mid", OP_STATUS, 8'd0, 16'd0, 1'b0, S_CAP, 16'((vcount + 3) / 4));
        cyc = 0;
        while ((vcount + 3) / 4 < DEPTH && cyc < 1000) begin
            rand_beat();
            cyc++;
        end
        check("d3_budget", 32'((vcount + 3) / 4), 32'(DEPTH));
        check("d3_done", 32'(done_o), 32'd1);
        check("d3_busy", 32'(busy_o), 32'd0);
        cmd_check("d3_rd_a3",  OP_READ, 8'd0, 16'd3,  1'b0, S_DONE, 16'h000C);
        cmd_check("d3_rd_a15", OP_READ, 8'd1, 16'd15, 1'b0, S_DONE, 16'h803C);
        cmd_check("d3_rd_a15c0", OP_READ, 8'd0, 16'd15, 1'b0, S_DONE, 16'h003C);

        // Errors while capturing leave the state alone.
        cmd_check("cap_arm",    OP_ARM,    8'd0, 16'd0, 1'b0, S_CAP, 16'h0000);
        cmd_check("cap_read",   OP_READ,   8'd0, 16'd0, 1'b1, S_CAP, 16'h0000);
        cmd_check("cap_op7",    3'd7,      8'd0, 16'd0, 1'b1, S_CAP, 16'h0000);
        cmd_check("cap_rd_ch5", OP_READ,   8'd5, 16'd0, 1'b1, S_CAP, 16'h0000);
        cmd_check("cap_status", OP_STATUS, 8'd0, 16'd0, 1'b0, S_CAP, 16'h0000);
        check("cap_busy", 32'(busy_o), 32'd1);

        // ARM detected on the edge of the 16th write: ARM wins, no DONE, write lost.
        for (int i = 0; i < DEPTH - 1; i++) begin
            frame(1'b1, 16'(16'h0100 + i), 16'h55AA);
        end
        check("pre_coll_done", 32'(done_o), 32'd0);
        tgl          = ~tgl;
        cmd_i        = {tgl, OP_ARM, 4'h0, 8'd0, 16'd0};
        tick();
        adc_tvalid_i = 1'b1;
        adc_tdata_i  = 32'h0BAD_0BAD;
        tick();
        adc_tvalid_i = 1'b0;
        check("coll_done_b", 32'(done_o), 32'd0);
        check("coll_busy_b", 32'(busy_o), 32'd1);
        tick();
        check("coll_rsp", rsp_o, exp_rsp(1'b0, S_CAP, 16'h0000));
        check("coll_done_c", 32'(done_o), 32'd0);
        cmd_check("coll_status", OP_STATUS, 8'd0, 16'd0, 1'b0, S_CAP, 16'h0000);

        // ABORT keeps RAM; reads in IDLE return what was stored before.
        for (int i = 0; i < 4; i++) begin
            frame(1'b1, 16'(16'hA000 + i), 16'hF00D);
        end
        cmd_check("abort", OP_ABORT, 8'd0, 16'd0, 1'b0, S_IDLE, 16'h0000);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        cmd_check("idle_rd_a2",  OP_READ,   8'd0, 16'd2,  1'b0, S_IDLE, 16'hA002);
        cmd_check("idle_rd_a1",  OP_READ,   8'd1, 16'd1,  1'b0, S_IDLE, 16'hF00D);
        cmd_check("idle_rd_a10", OP_READ,   8'd0, 16'd10, 1'b0, S_IDLE, 16'h010A);
        cmd_check("idle_rd_a15", OP_READ,   8'd0, 16'd15, 1'b0, S_IDLE, 16'h003C);
        cmd_check("idle_status", OP_STATUS, 8'd0, 16'd0,  1'b0, S_IDLE, 16'h0004);

        // Reset mid-capture with toggle 1 held on cmd_i.
        cmd_check("rst_arm", OP_ARM, 8'd0, 16'd0, 1'b0, S_CAP, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            frame(1'b1, 16'(i), 16'(i));
        end
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        rst   = 1'b1;
        cmd_i = 32'h8000_0000;
        #1;
        check("async_rsp", rsp_o, 32'd0);
        check("async_busy", 32'(busy_o), 32'd0);
        check("async_done", 32'(done_o), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tgl = 1'b1;
        repeat (2) tick();
        check("post_rst_early", rsp_o, 32'd0);
        tick();
        check("post_rst_ack", rsp_o, 32'h8000_0000);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        repeat (4) tick();
        check("post_rst_hold", rsp_o, 32'h8000_0000);
        cmd_check("post_rst_status", OP_STATUS, 8'd0, 16'd0, 1'b0, S_IDLE, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
